// File: rtl/lsu_mem_ctrl.sv
// Load/store unit controller: turns one accepted load/store into a request/ready
// memory transaction with lane steering, load extension, pipeline stall and error reporting.
module lsu_mem_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        MemtoReg,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [4:0]  rd_in,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        err,
   output logic [1:0]  err_code
);
   localparam int unsigned      CNT_W    = 10;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [4:0]       rd_q, rd_nx;
   logic             to_reg_q, to_reg_nx;
   logic [2:0]       f3_q, f3_nx;
   logic [1:0]       off_q, off_nx;
   logic             mem_req_nx, mem_we_nx, wb_valid_nx, err_nx;
   logic [31:0]      mem_addr_nx, mem_wdata_nx, wb_data_nx;
   logic [3:0]       mem_be_nx;
   logic [4:0]       wb_rd_nx;
   logic [1:0]       err_code_nx;
   logic             access, illegal, misaligned;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [31:0]      ld_ext;

   assign access = MemRead | MemWrite;
   assign stall  = ((state == IDLE) & access) | (state == REQ);

   // Access decode: funct3[1:0] encodes the size, funct3[2] the unsigned load variants.
   assign illegal = (MemRead & MemWrite)
                  | (MemRead & ((funct3[1:0] == 2'b11) | (funct3[2:1] == 2'b11)))
                  | (MemWrite & (funct3[2] | (funct3[1:0] == 2'b11)));
   assign misaligned = ((funct3[1:0] == 2'b01) & addr[0])
                     | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));

   // Load lane select and extension, taken straight from the returning read data.
   always_comb begin
      ld_byte = 8'(mem_rdata >> {off_q, 3'b000});
      ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {24'h0, ld_byte};
         3'b101:  ld_ext = {16'h0, ld_half};
         default: ld_ext = mem_rdata;
      endcase
   end

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      rd_nx        = rd_q;
      to_reg_nx    = to_reg_q;
      f3_nx        = f3_q;
      off_nx       = off_q;
      mem_req_nx   = 1'b0;
      mem_we_nx    = mem_we;
      mem_addr_nx  = mem_addr;
      mem_be_nx    = mem_be;
      mem_wdata_nx = mem_wdata;
      wb_valid_nx  = 1'b0;
      wb_rd_nx     = wb_rd;
      wb_data_nx   = wb_data;
      err_nx       = 1'b0;
      err_code_nx  = err_code;
      case (state)
         IDLE: begin
            if (access) begin
               rd_nx     = rd_in;
               to_reg_nx = MemtoReg;
               f3_nx     = funct3;
               off_nx    = addr[1:0];
               if (illegal) begin
                  state_nx    = ERR;
                  err_nx      = 1'b1;
                  err_code_nx = 2'b11;
               end else if (misaligned) begin
                  state_nx    = ERR;
                  err_nx      = 1'b1;
                  err_code_nx = 2'b01;
               end else begin
                  state_nx    = REQ;
                  cnt_nx      = '0;
                  mem_req_nx  = 1'b1;
                  mem_we_nx   = MemWrite;
                  mem_addr_nx = {addr[31:2], 2'b00};
                  case (funct3[1:0])
                     2'b00: begin
                        mem_be_nx    = 4'b0001 << addr[1:0];
                        mem_wdata_nx = {4{wdata[7:0]}};
                     end
                     2'b01: begin
                        mem_be_nx    = addr[1] ? 4'b1100 : 4'b0011;
                        mem_wdata_nx = {2{wdata[15:0]}};
                     end
                     default: begin
                        mem_be_nx    = 4'b1111;
                        mem_wdata_nx = wdata;
                     end
                  endcase
               end
            end
         end
         REQ: begin
            // Completion beats the timeout when both land on the same cycle.
            if (mem_ready) begin
               state_nx = DONE;
               if (!mem_we && to_reg_q) begin
                  wb_valid_nx = 1'b1;
                  wb_rd_nx    = rd_q;
                  wb_data_nx  = ld_ext;
               end
            end else if (cnt == CNT_LAST) begin
               state_nx    = ERR;
               err_nx      = 1'b1;
               err_code_nx = 2'b10;
            end else begin
               cnt_nx     = cnt + CNT_W'(1);
               mem_req_nx = 1'b1;
            end
         end
         DONE:    state_nx = IDLE;
         ERR:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         rd_q      <= '0;
         to_reg_q  <= 1'b0;
         f3_q      <= '0;
         off_q     <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
         wb_valid  <= 1'b0;
         wb_rd     <= '0;
         wb_data   <= '0;
         err       <= 1'b0;
         err_code  <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         rd_q      <= rd_nx;
         to_reg_q  <= to_reg_nx;
         f3_q      <= f3_nx;
         off_q     <= off_nx;
         mem_req   <= mem_req_nx;
         mem_we    <= mem_we_nx;
         mem_addr  <= mem_addr_nx;
         mem_be    <= mem_be_nx;
         mem_wdata <= mem_wdata_nx;
         wb_valid  <= wb_valid_nx;
         wb_rd     <= wb_rd_nx;
         wb_data   <= wb_data_nx;
         err       <= err_nx;
         err_code  <= err_code_nx;
      end
   end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: a driver predicts memory requests, writebacks and
// errors from access rules; a forked monitor pops and compares as the DUT presents them.
module tb_lsu_mem_ctrl;
   localparam int unsigned TO    = 8;
   localparam int          K_MEM = 0;
   localparam int          K_WB  = 1;
   localparam int          K_ERR = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MemRead, MemWrite, MemtoReg;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic [4:0]  rd_in;
   logic        stall, mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        wb_valid, err;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [1:0]  err_code;

   typedef struct {
      int          kind;
      logic [31:0] a;
      logic        we;
      logic [3:0]  be;
      logic [31:0] d;
      logic [4:0]  rd;
      logic [1:0]  code;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mem [256];
   int          ready_delay;
   int          wait_cnt;
   int          checks   = 0;
   int          failures = 0;

   lsu_mem_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .funct3(funct3), .addr(addr), .wdata(wdata), .rd_in(rd_in), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   // Memory responder: ready on the (ready_delay+1)-th request cycle, never if negative.
   assign mem_rdata = mem[mem_addr[9:2]];
   always @(negedge clk) begin
      if (mem_req && rst_n) begin
         mem_ready <= (ready_delay >= 0) && (wait_cnt == ready_delay);
         wait_cnt  <= wait_cnt + 1;
      end else begin
         mem_ready <= 1'b0;
         wait_cnt  <= 0;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] w);
      int unsigned off = a % 4;
      longint      v;
      case (f3)
         3'd0, 3'd4: v = longint'((w >> (8 * off)) % 256);
         3'd1, 3'd5: v = longint'((w >> (8 * off)) % 65536);
         default:    return w;
      endcase
      if (f3 == 3'd0 && v >= 128)   v -= 256;
      if (f3 == 3'd1 && v >= 32768) v -= 65536;
      return 32'(v);
   endfunction

   task automatic monitor();
      exp_t        e;
      logic        prev_req = 1'b0;
      logic [36:0] ctl0;
      logic [31:0] d0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_req = 1'b0;
            continue;
         end
         if (mem_req && !prev_req) begin
            ctl0 = {mem_we, mem_be, mem_addr};
            d0   = mem_wdata;
            chk("mem_req_expected", sb.size() > 0 && sb[0].kind == K_MEM, 1);
            if (sb.size() > 0 && sb[0].kind == K_MEM) begin
               e = sb.pop_front();
               chk("mem_addr", mem_addr, e.a);
               chk("mem_we", mem_we, e.we);
               chk("mem_be", mem_be, e.be);
               if (e.we) chk("mem_wdata", mem_wdata, e.d);
            end
         end else if (mem_req) begin
            chk("req_hold_ctl", {mem_we, mem_be, mem_addr}, ctl0);
            chk("req_hold_wdata", mem_wdata, d0);
         end
         prev_req = mem_req;
         if (wb_valid) begin
            chk("wb_expected", sb.size() > 0 && sb[0].kind == K_WB, 1);
            if (sb.size() > 0 && sb[0].kind == K_WB) begin
               e = sb.pop_front();
               chk("wb_rd", wb_rd, e.rd);
               chk("wb_data", wb_data, e.d);
            end
         end
         if (err) begin
            chk("err_expected", sb.size() > 0 && sb[0].kind == K_ERR, 1);
            if (sb.size() > 0 && sb[0].kind == K_ERR) begin
               e = sb.pop_front();
               chk("err_code", err_code, e.code);
            end
         end
      end
   endtask

   task automatic issue(input bit rd_en, input bit wr_en, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rdi,
                        input bit m2r, input int dly, input bit rst_mid);
      exp_t        e;
      int unsigned sz, off, stalls, exp_stalls, n;
      bit          illegal, mis, legal, tmo;
      logic [31:0] mask;
      illegal = (rd_en && wr_en)
             || (rd_en && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
             || (wr_en && !(f3 inside {3'd0, 3'd1, 3'd2}));
      sz    = 1 << f3[1:0];
      off   = a % 4;
      mis   = !illegal && (a % sz != 0);
      legal = !illegal && !mis;
      tmo   = legal && (rst_mid || dly < 0 || dly >= int'(TO));
      e = '{kind: K_ERR, a: 0, we: 0, be: 0, d: 0, rd: 0, code: 0};
      if (!legal) begin
         e.code = illegal ? 2'b11 : 2'b01;
         sb.push_back(e);
      end else begin
         e.kind = K_MEM;
         e.a    = a & ~32'h3;
         e.we   = wr_en;
         e.be   = 4'((sz == 4) ? 15 : ((sz == 2 ? 3 : 1) << off));
         e.d    = (sz == 1) ? (wd % 256) * 32'h01010101 :
                  (sz == 2) ? (wd % 65536) * 32'h00010001 : wd;
         sb.push_back(e);
         if (tmo && !rst_mid) begin
            e.kind = K_ERR;
            e.code = 2'b10;
            sb.push_back(e);
         end else if (!tmo && !wr_en && m2r) begin
            e.kind = K_WB;
            e.rd   = rdi;
            e.d    = load_val(f3, a, mem[a[9:2]]);
            sb.push_back(e);
         end else if (!tmo && wr_en) begin
            mask = 0;
            for (int i = 0; i < 4; i++) if (e.be[i]) mask |= 32'hFF << (8 * i);
            mem[a[9:2]] = (mem[a[9:2]] & ~mask) | (e.d & mask);
         end
      end
      exp_stalls  = legal ? 1 + (tmo ? TO : int'(dly) + 1) : 1;
      ready_delay = tmo ? -1 : dly;

      @(negedge clk);
      MemRead = rd_en; MemWrite = wr_en; MemtoReg = m2r;
      funct3 = f3; addr = a; wdata = wd; rd_in = rdi;
      #1 chk("stall_accept", stall, 1);
      @(negedge clk);
      chk("req_at_T1", mem_req, legal);
      chk("err_at_T1", err, !legal);
      if (rst_mid) begin
         repeat (2) @(negedge clk);
         MemRead = 1'b0; MemWrite = 1'b0;
         #2 rst_n = 1'b0;
         #1 chk("rst_drops_req", mem_req, 0);
         chk("rst_stall", stall, 0);
         @(negedge clk);
         rst_n = 1'b1;
         repeat (TO + 4) @(negedge clk);
         return;
      end
      stalls = 1;
      n = 0;
      while (stall && n < 4 * TO + 20) begin
         stalls++;
         n++;
         @(negedge clk);
      end
      chk("stall_cycles", stalls, exp_stalls);
      MemRead = 1'b0; MemWrite = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   initial begin
      logic [2:0]  f3;
      logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      bit          rd_en, wr_en;
      int          r, dly;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; funct3 = '0;
      addr = '0; wdata = '0; rd_in = '0; ready_delay = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #3;
      chk("rst_ctl", {stall, mem_req, mem_we, mem_be, wb_valid, wb_rd, err, err_code}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_wb_data", wb_data, 0);
      fork
         monitor();
      join_none
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      mem[32'h100 >> 2] = 32'hDEADBEEF;
      issue(1, 0, 3'd2, 32'h100, 32'h0, 5'd7, 1, 0, 0);
      mem[32'h203 >> 2] = 32'h80FFFFFF;
      issue(1, 0, 3'd0, 32'h203, 32'h0, 5'd3, 1, 0, 0);
      issue(1, 0, 3'd4, 32'h203, 32'h0, 5'd4, 1, 0, 0);
      issue(1, 0, 3'd1, 32'h202, 32'h0, 5'd5, 1, 0, 0);
      issue(0, 1, 3'd0, 32'h11, 32'h000000A5, 5'd0, 0, 0, 0);
      issue(0, 1, 3'd1, 32'h12, 32'h00001234, 5'd0, 0, 0, 0);
      issue(1, 0, 3'd2, 32'h100, 32'h0, 5'd9, 1, 5, 0);
      issue(1, 0, 3'd2, 32'h102, 32'h0, 5'd1, 1, 0, 0);
      issue(1, 1, 3'd2, 32'h100, 32'h0, 5'd1, 1, 0, 0);
      issue(0, 1, 3'd4, 32'h100, 32'h0, 5'd1, 0, 0, 0);
      issue(1, 0, 3'd2, 32'h104, 32'h0, 5'd2, 1, -1, 0);
      issue(1, 0, 3'd2, 32'h108, 32'h0, 5'd2, 1, int'(TO) - 1, 0);
      issue(1, 0, 3'd1, 32'h10A, 32'h0, 5'd6, 0, 0, 0);
      issue(1, 0, 3'd2, 32'h10C, 32'h0, 5'd8, 1, 0, 1);

      for (int i = 0; i < 200; i++) begin
         r = $urandom_range(0, 9);
         rd_en = (r < 6) || (r == 9);
         wr_en = (r >= 6);
         if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
         else if (wr_en)                f3 = 3'($urandom_range(0, 2));
         else                           f3 = ld_f3[$urandom_range(0, 4)];
         r = $urandom_range(0, 19);
         if (r < 14)      dly = $urandom_range(0, 2);
         else if (r < 18) dly = $urandom_range(3, TO - 1);
         else             dly = -1;
         issue(rd_en, wr_en, f3, 32'h100 + 32'($urandom_range(0, 63)), $urandom,
               5'($urandom_range(0, 31)), $urandom_range(0, 7) != 0, dly, 0);
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit controller on the consumer side of the decoder's memory control outputs (MemRead, MemWrite, MemtoReg).
- Turns an accepted load or store into a single request/ready transaction on the data-memory port.
- Generates byte enables and lane-replicated store data, and sign- or zero-extends load data before writeback.
- Holds the core pipeline with `stall` until the access completes, and reports misaligned, illegal or timed-out accesses.

Parameters:
- TIMEOUT, 255: cycles to wait in REQ for `mem_ready` before aborting with a timeout error; legal range 1..1023.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MemRead  in  1  load requested by the decoder.
- MemWrite  in  1  store requested by the decoder.
- MemtoReg  in  1  load result goes to the register file.
- funct3  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- addr  in  32  effective byte address (ALU result).
- wdata  in  32  store data (rs2).
- rd_in  in  5  destination register of the load.
- stall  out  1  pipeline hold.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ready  in  1  memory accept/complete.
- mem_rdata  in  32  read data; valid when `mem_req & mem_ready`.
- wb_valid  out  1  one-cycle load writeback pulse.
- wb_rd  out  5  writeback register.
- wb_data  out  32  extended load data.
- err  out  1  one-cycle error pulse.
- err_code  out  2  01 misaligned, 10 timeout, 11 illegal.

Behaviour:
- States: IDLE, REQ, DONE, ERR.
- Reset: state IDLE; all outputs, `wb_data` and the timeout counter cleared to 0. Reset in any state drops `mem_req` immediately, with no writeback and no error.
- Accept (IDLE, cycle T): `MemRead | MemWrite` high. `rd_in`, `MemtoReg`, direction, `funct3` and `addr[1:0]` are captured. Upstream holds its inputs stable while `stall` = 1.
- Decode checks at T, in priority order:
  - `MemRead & MemWrite`, a load with `funct3` in {011, 110, 111}, or a store with `funct3` not in {000, 001, 010} -> ERR, code 11.
  - Misaligned -> ERR, code 01. Misaligned means halfword with `addr[0]` = 1, or word with `addr[1:0]` != 00.
  - Otherwise -> REQ.
- REQ:
  - `mem_req` = 1 (registered).
  - `mem_addr` = {addr[31:2], 00}.
  - `mem_we` = store.
  - `mem_be`: byte = 1 << addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111. Loads use the same `mem_be`.
  - `mem_wdata`: byte replicated x4; half replicated x2; word unchanged.
  - All memory outputs are stable until `mem_ready`.
  - On `mem_ready` -> DONE. For a load, `mem_rdata` is latched in the same cycle.
  - The counter increments each REQ cycle without `mem_ready`. On reaching TIMEOUT, `mem_req` drops -> ERR, code 10. If `mem_ready` arrives on the TIMEOUT-th cycle, completion wins.
- DONE (one cycle):
  - For a load with captured `MemtoReg` = 1: `wb_valid` = 1; `wb_rd` = captured rd; `wb_data` = the selected byte/half, sign-extended (LB, LH) or zero-extended (LBU, LHU), or the full word (LW).
  - Stores and loads with `MemtoReg` = 0 produce no `wb_valid`.
  - Next state: IDLE.
- ERR (one cycle): `err` = 1 with `err_code`; no memory access, no writeback; next state IDLE.
- `stall` (combinational) = (IDLE & (MemRead | MemWrite)) | REQ. `stall` = 0 in DONE and ERR, so the pipeline advances.
- Inputs are ignored in DONE and ERR; a back-to-back access is accepted in the following IDLE cycle.
- `wb_data`, `wb_rd` and `err_code` hold their values between pulses.
- Latency with `mem_ready` held high: accept at T, `mem_req` at T+1, `wb_valid` at T+2, `stall` high during T..T+1.

Test Plan:
- LW, addr=0x100, mem_ready tied 1, rdata=0xDEADBEEF -> mem_req@T+1, mem_be=1111, mem_addr=0x100; wb_valid@T+2 with wb_data=0xDEADBEEF, rd=rd_in; stall high exactly 2 cycles.
- LB addr=0x203 with rdata=0x80FFFFFF -> wb_data=0xFFFFFF80, mem_be=1000. LBU at the same address -> 0x00000080. LH at addr 0x202 -> 0xFFFF80FF.
- SB addr=0x11, wdata=0x000000A5 -> mem_we=1, mem_be=0010, mem_wdata=0xA5A5A5A5, no wb_valid. SH addr=0x12, wdata=0x1234 -> mem_be=1100, mem_wdata=0x12341234.
- mem_ready delayed 5 cycles -> mem_req/addr/be stable for all 6 REQ cycles, stall high for 6 cycles plus the accept cycle, then normal DONE.
- LW at addr 0x102 -> err=1, code 01, at T+1, no mem_req ever. MemRead & MemWrite together -> code 11. Store with funct3 100 -> code 11.
- TIMEOUT=4, mem_ready never asserted -> mem_req high 4 cycles then low, err code 10. Separately, rst_n pulsed low mid-REQ -> mem_req=0 immediately; no wb_valid or err after reset release.
